bootrom_read_ctrl: RTL and testbench
====================================

// Module: bootrom_read_ctrl
// PURPOSE
//   Read initiator for the BootROM macro. Turns a burst read request on a
//   valid/ready channel into word reads on the ROM's me/oe/address/q port.
//   ROM data has 1-cycle latency, so read data is held in a 2-entry response
//   buffer, which handles consumer backpressure.
//   Sits between the boot fetch path (ZSBL fetch / debug loader) and BootROM.
// PARAMETERS
//   DEPTH   2048          ROM depth in 32-bit words; rom_address width is clog2(DEPTH)
//   BASE    32'h0001_0000 byte address mapped to ROM word 0
//   ADDR_W  32            request byte-address width
//   LEN_W   4             burst length field width; beats = req_len+1 (1..16)
// PORTS
//   clock        in   1       single clock, all logic on posedge
//   reset        in   1       asynchronous, active-high
//   req_valid    in   1       burst request valid
//   req_ready    out  1       request accepted when valid&ready
//   req_addr     in   ADDR_W  start byte address; bits [1:0] ignored
//   req_len      in   LEN_W   beats minus one
//   rsp_valid    out  1       response beat valid
//   rsp_ready    in   1       consumer accepts beat
//   rsp_data     out  32      read word (0 when rsp_error)
//   rsp_error    out  1       beat address outside [BASE, BASE+4*DEPTH)
//   rsp_last     out  1       final beat of the burst
//   rom_me       out  1       ROM read enable (one read per cycle high)
//   rom_oe       out  1       ROM output enable
//   rom_address  out  11      ROM word index (clog2(DEPTH))
//   rom_q        in   32      ROM data, valid the cycle after rom_me
// BEHAVIOUR
// - Reset (async): state IDLE, buffer empty, in-flight cleared.
//   rsp_valid=0, rom_me=0, rom_oe=0, rom_address=0, rsp_data/error/last=0.
// - States: IDLE -> BURST on req handshake.
//   BURST -> IDLE on the edge where the rsp_last beat hands off (rsp_valid&rsp_ready&rsp_last).
//   req_ready = (state==IDLE). No overlap between bursts.
// - On accept: idx = (req_addr-BASE)>>2 computed at ADDR_W+1 bits.
//   A borrow marks "below range". Also latch beats = req_len+1 and issued=0.
// - Issue slot (BURST): a slot is taken when issued<beats and
//   (buf_count + inflight - pop) < 2, where pop = rsp_valid&rsp_ready this cycle.
//   In-range slot: rom_me=1, rom_address=idx[10:0].
//   Out-of-range slot (below BASE, or idx>=DEPTH): rom_me=0. A zero-data error entry
//   takes the same pipeline slot. No wrap-around past the ROM end.
//   Each slot increments idx and issued. At most one slot per cycle.
// - rom_oe is registered: rom_oe equals the previous cycle's slot-taken flag.
//   rom_q is sampled only when rom_oe=1.
// - Capture: at the end of the cycle after a slot, push {rom_q or 0, error, last}
//   into the 2-entry FIFO. last = (slot index == beats-1).
// - Latency: first rsp_valid goes high 2 cycles after the accepting edge.
//   With rsp_ready held 1, throughput is 1 beat/cycle.
// - Payload rules: while rsp_valid&!rsp_ready, rsp_data/error/last stay stable.
//   Beats are returned in address order, none dropped or duplicated.
// - Buffer full (count+inflight==2 with no pop): no rom_me. The buffer never overflows.
// - Push and pop in the same cycle are both honoured; count is unchanged.
// - Reset mid-burst: async clear. The in-flight ROM read is discarded and rsp_valid
//   drops immediately. After release, req_ready=1.
// TESTING
// 1 Reset asserted mid-idle and mid-burst -> rsp_valid=0, rom_me=0, rom_oe=0
//   immediately; req_ready=1 after release.
// 2 Single beat at BASE+0x8, rom[2]=32'hDEADBEEF -> rsp_data=DEADBEEF, last=1,
//   error=0; rsp_valid 2 cycles after accept.
// 3 Burst len=3 at BASE, rsp_ready=1 -> rom_me high 4 consecutive cycles, addr 0..3.
//   rsp on 4 consecutive cycles = rom[0..3]; last only on 4th.
// 4 Burst len=7, rsp_ready toggling 1,0,1,0 -> all 8 words in order.
//   Never more than 2 buffered+inflight; payload stable while stalled.
// 5 Burst len=2 at BASE+0x1FFC -> beat0 = rom[2047], error=0.
//   Beats 1-2 data 0, error=1. rom_me high exactly once.
// 6 Request at BASE-4, len=0 -> single beat, error=1, data 0, last=1, no rom_me;
//   then a new request is accepted next cycle.

Source files
------------

// File: rtl/bootrom_read_ctrl_if.sv
// Request/response channel between a boot fetch initiator and the BootROM reader.
// Latency: none, wires only.
// Backpressure: valid/ready on both channels; the response channel is stalled by rsp_ready.
interface bootrom_read_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_error;
  logic              rsp_last;

  // Initiator side: issues bursts, consumes beats.
  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error, rsp_last
  );

  // Reader side: accepts bursts, produces beats.
  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error, rsp_last
  );
endinterface

// File: rtl/bootrom_read_ctrl.sv
// Turns burst read requests into one-word-per-cycle BootROM reads, returning beats in order.
// Latency: first rsp_valid two edges after the accepting edge; 1 beat/cycle when unstalled.
// Backpressure: 2-entry response buffer; no ROM read is issued unless a buffer slot is guaranteed.
module bootrom_read_ctrl #(
  parameter int                ADDR_W = 32,
  parameter int                LEN_W  = 4,
  parameter int                DEPTH  = 2048,
  parameter logic [ADDR_W-1:0] BASE   = 32'h0001_0000,
  localparam int               IDX_W  = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  bootrom_read_ctrl_if.slave   bus,
  output logic                 rom_me,
  output logic                 rom_oe,
  output logic [IDX_W-1:0]     rom_address,
  input  logic [31:0]          rom_q
);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } entry_t;

  localparam logic [ADDR_W:0]   IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0]    LEN_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  state_t         state_q, state_d;
  // Word index relative to BASE, one extra bit so a start below BASE reads as negative.
  logic [ADDR_W:0] idx_q, idx_d;
  logic [LEN_W:0]  beats_q, beats_d;
  logic [LEN_W:0]  issued_q, issued_d;
  // Slot taken last cycle; its data (or error marker) is captured this cycle.
  logic            inflight_q, inflight_d;
  logic            infl_err_q, infl_err_d;
  logic            infl_last_q, infl_last_d;
  logic [1:0]      cnt_q, cnt_d;
  entry_t          e0_q, e0_d;
  entry_t          e1_q, e1_d;

  logic            pop;
  logic            push;
  logic            in_range;
  logic            slot;
  logic            slot_last;
  logic [2:0]      occ;
  entry_t          push_ent;

  assign pop       = (cnt_q != 2'd0) && bus.rsp_ready;
  assign push      = inflight_q;
  assign in_range  = !idx_q[ADDR_W] && (idx_q[ADDR_W-1:0] < DEPTH_W);
  // Occupancy after this cycle's pop; a new slot must fit even if nothing drains later.
  assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign slot      = (state_q == BURST) && (issued_q < beats_q) && (occ < 3'd2);
  assign slot_last = (issued_q == (beats_q - LEN_ONE));

  // Error entries never look at rom_q, so stale ROM output cannot leak out.
  assign push_ent.dat  = infl_err_q ? 32'h0 : rom_q;
  assign push_ent.err  = infl_err_q;
  assign push_ent.last = infl_last_q;

  assign rom_me        = slot && in_range;
  assign rom_address   = rom_me ? idx_q[IDX_W-1:0] : '0;
  assign rom_oe        = inflight_q;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (cnt_q != 2'd0);
  assign bus.rsp_data  = bus.rsp_valid ? e0_q.dat  : 32'h0;
  assign bus.rsp_error = bus.rsp_valid ? e0_q.err  : 1'b0;
  assign bus.rsp_last  = bus.rsp_valid ? e0_q.last : 1'b0;

  // Burst sequencing, issue slots and the response buffer next-state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    beats_d     = beats_q;
    issued_d    = issued_q;
    inflight_d  = slot;
    infl_err_d  = slot ? !in_range : 1'b0;
    infl_last_d = slot ? slot_last : 1'b0;
    cnt_d       = cnt_q;
    e0_d        = e0_q;
    e1_d        = e1_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Arithmetic shift keeps the borrow so below-BASE addresses stay out of range.
          idx_d    = ($signed({1'b0, bus.req_addr} - {1'b0, BASE})) >>> 2;
          beats_d  = {1'b0, bus.req_len} + LEN_ONE;
          issued_d = '0;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (slot) begin
          idx_d    = idx_q + IDX_ONE;
          issued_d = issued_q + LEN_ONE;
        end
        if (pop && e0_q.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_ent;
        else               e1_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = push_ent;
        end else begin
          e0_d = e1_q;
          e1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset discards any in-flight read and empties the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      beats_q     <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_err_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      e0_q        <= '0;
      e1_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      beats_q     <= beats_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_err_q  <= infl_err_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
    end
  end

endmodule

// File: tb/tb_bootrom_read_ctrl.sv
// Directed and randomized bursts against a ROM model, checked by an address-level reference.
// Latency: expected beats derived per beat address; response timing checked in edges.
// Backpressure: rsp_ready held, toggled or randomized per burst.
module tb_bootrom_read_ctrl;
  localparam int          DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        rom_me;
  logic        rom_oe;
  logic [10:0] rom_address;
  logic [31:0] rom_q;
  logic [31:0] rom_mem [DEPTH];

  initial forever #5 clock = ~clock;

  // ROM macro model: one-cycle read latency.
  always @(posedge clock) if (rom_me) rom_q <= rom_mem[rom_address];

  bootrom_read_ctrl_if #(.ADDR_W(32), .LEN_W(4)) bus ();

  bootrom_read_ctrl #(.ADDR_W(32), .LEN_W(4), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .rom_me      (rom_me),
    .rom_oe      (rom_oe),
    .rom_address (rom_address),
    .rom_q       (rom_q)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          exp_addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pushes, pops, pops_b;
  int          accept_cyc, lat;
  bit          first_seen;
  int          first_pop, last_pop;
  int          rom_me_cnt, first_me, last_me, exp_me;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_err, prev_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Observe one cycle at the falling edge, away from the DUT's active edge.
  task automatic sample();
    int    buffered;
    beat_t e;
    cyc++;
    if (reset) return;
    buffered = pushes - pops;
    chk("occupancy_le_2", 32'((buffered + int'(rom_oe)) <= 2), 32'd1);
    chk("rsp_valid_vs_buffer", 32'(bus.rsp_valid), 32'(buffered != 0));
    if (prev_stall) begin
      chk("stall_data", bus.rsp_data, prev_data);
      chk("stall_error", 32'(bus.rsp_error), 32'(prev_err));
      chk("stall_last", 32'(bus.rsp_last), 32'(prev_last));
    end
    if (rom_me === 1'b1) begin
      rom_me_cnt++;
      if (rom_me_cnt == 1) first_me = cyc;
      last_me = cyc;
      chk("rom_me_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) chk("rom_address", 32'(rom_address), 32'(exp_addr_q.pop_front()));
    end
    if (bus.req_valid && bus.req_ready) begin
      accept_cyc = cyc;
      first_seen = 1'b0;
    end
    if (bus.rsp_valid && !first_seen) begin
      first_seen = 1'b1;
      // The accept is sampled half a cycle before its edge; count edges after that edge.
      lat = cyc - accept_cyc - 1;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_error", 32'(bus.rsp_error), 32'(e.err));
        chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
      end
      if (pops_b == 0) first_pop = cyc;
      last_pop = cyc;
      pops_b++;
      pops++;
    end
    if (rom_oe) pushes++;
    prev_stall = bus.rsp_valid && !bus.rsp_ready;
    prev_data  = bus.rsp_data;
    prev_err   = bus.rsp_error;
    prev_last  = bus.rsp_last;
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_addr_q.delete();
    pushes     = 0;
    pops       = 0;
    prev_stall = 1'b0;
    first_seen = 1'b1;
  endtask

  // Reference: beat i reads byte address (addr & ~3) + 4*i, in range iff inside the ROM window.
  task automatic start_burst(input logic [31:0] addr, input logic [3:0] len);
    longint a;
    bit     inr;
    beat_t  b;
    exp_me     = 0;
    rom_me_cnt = 0;
    pops_b     = 0;
    lat        = -1;
    for (int i = 0; i <= int'(len); i++) begin
      a      = longint'({32'b0, addr & 32'hFFFF_FFFC}) + longint'(4 * i);
      inr    = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
      b.data = inr ? rom_mem[int'((a - longint'(BASE)) / 4)] : 32'h0;
      b.err  = !inr;
      b.last = (i == int'(len));
      exp_q.push_back(b);
      if (inr) begin
        exp_addr_q.push_back(int'((a - longint'(BASE)) / 4));
        exp_me++;
      end
    end
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
  endtask

  task automatic run_burst(input int mode, input logic [3:0] len);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      case (mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = (n % 2 == 0);
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      n++;
    end
    chk("burst_complete", 32'(exp_q.size()), 32'd0);
    chk("rsp_latency", 32'(lat), 32'd2);
    chk("rom_me_count", 32'(rom_me_cnt), 32'(exp_me));
    chk("req_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    if (mode == 0) chk("throughput", 32'(last_pop - first_pop), 32'(len));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rom_me"}, 32'(rom_me), 32'd0);
    chk({tag, "_rom_oe"}, 32'(rom_oe), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          off;
    logic [3:0]  len;
    int          mode;

    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rom_mem[2]    = 32'hDEAD_BEEF;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    clear_model();

    #1;
    check_reset_outputs("por");
    chk("por_rom_address", 32'(rom_address), 32'd0);
    chk("por_rsp_data", bus.rsp_data, 32'd0);
    chk("por_rsp_error", 32'(bus.rsp_error), 32'd0);
    chk("por_rsp_last", 32'(bus.rsp_last), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("por_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset while idle.
    tick();
    #2 reset = 1'b1;
    #1 check_reset_outputs("idle_rst");
    repeat (2) tick();
    reset = 1'b0;
    clear_model();
    chk("idle_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset mid-burst with the buffer stalled full.
    bus.rsp_ready = 1'b0;
    start_burst(BASE, 4'd7);
    repeat (4) tick();
    chk("stalled_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("burst_rst");
    repeat (2) tick();
    reset = 1'b0;
    clear_model();
    chk("burst_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Single beat from word 2.
    start_burst(BASE + 32'h8, 4'd0);
    run_burst(0, 4'd0);

    // Four-beat burst at BASE with no stall.
    start_burst(BASE, 4'd3);
    run_burst(0, 4'd3);
    chk("rom_me_span", 32'(last_me - first_me), 32'd3);

    // Eight-beat burst under alternating backpressure.
    start_burst(BASE + 32'h100, 4'd7);
    run_burst(1, 4'd7);

    // Burst running off the top of the ROM.
    start_burst(BASE + 32'h1FFC, 4'd2);
    run_burst(0, 4'd2);

    // Request below BASE, then an immediate follow-on request.
    start_burst(BASE - 32'h4, 4'd0);
    run_burst(0, 4'd0);
    start_burst(BASE + 32'h40, 4'd1);
    run_burst(0, 4'd1);

    // Randomized bursts around and inside the ROM window.
    repeat (40) begin
      off  = int'($urandom_range(0, 4 * DEPTH + 128)) - 64;
      addr = BASE + 32'(off);
      len  = 4'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 2));
      start_burst(addr, len);
      run_burst(mode, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
